// File: rtl/nibble_mon_pkg.sv
// Shared widths, pattern-FSM states and nibble arithmetic for the nibble stream monitor.
package nibble_mon_pkg;

  localparam int unsigned NIB_W = 4;
  localparam int unsigned SCNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GOT0 = 2'd1,
    S_GOT1 = 2'd2
  } state_e;

  // Modular nibble addition; the carry out is intentionally discarded.
  function automatic logic [NIB_W-1:0] nib_add(input logic [NIB_W-1:0] a,
                                               input logic [NIB_W-1:0] b);
    logic [NIB_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[NIB_W-1:0];
  endfunction

endpackage

// File: rtl/nibble_fifo.sv
// Show-ahead nibble FIFO; a push into a full FIFO is accepted only when a pop frees a slot.
module nibble_fifo
  import nibble_mon_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [NIB_W-1:0] din,
  input  logic             pop,
  output logic [NIB_W-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FCNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] count_q, count_d;
  logic [NIB_W-1:0]  mem_q [DEPTH];
  logic [NIB_W-1:0]  mem_d [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty = (count_q == FCNT_W'(0));
  assign full  = (count_q == FCNT_W'(DEPTH));
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer/count update; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + FCNT_W'(1);
      2'b01:   count_d = count_q - FCNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: dout is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/nibble_stream_monitor.sv
// Consumes the generator nibble stream: buffers it, detects a 3-nibble pattern,
// checks the fixed step between samples, counts samples and flags FIFO overflow.
module nibble_stream_monitor
  import nibble_mon_pkg::*;
#(
  parameter int unsigned      DEPTH = 4,
  parameter logic [NIB_W-1:0] PAT0  = 4'h3,
  parameter logic [NIB_W-1:0] PAT1  = 4'h4,
  parameter logic [NIB_W-1:0] PAT2  = 4'h5,
  parameter logic [NIB_W-1:0] STEP  = 4'h1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NIB_W-1:0]  q_in,
  input  logic              valid_in,
  output logic [NIB_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              match,
  output logic              step_err,
  output logic              overflow,
  output logic [SCNT_W-1:0] sample_cnt
);

  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_pop;

  state_e            state_q, state_d;
  logic [NIB_W-1:0]  prev_q, prev_d;
  logic              have_prev_q, have_prev_d;
  logic              match_q, match_d;
  logic              step_err_q, step_err_d;
  logic              overflow_q, overflow_d;
  logic [SCNT_W-1:0] cnt_q, cnt_d;

  assign out_valid = ~fifo_empty;
  assign fifo_pop  = ~fifo_empty & out_ready;

  nibble_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (valid_in),
    .din  (q_in),
    .pop  (fifo_pop),
    .dout (out_data),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  // Pattern FSM, step checker, sample counter and sticky overflow.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    match_d     = 1'b0;
    step_err_d  = 1'b0;
    overflow_d  = overflow_q | (valid_in & fifo_full & ~fifo_pop);
    cnt_d       = cnt_q;

    if (valid_in) begin
      prev_d      = q_in;
      have_prev_d = 1'b1;
      step_err_d  = have_prev_q & (q_in != nib_add(prev_q, STEP));
      if (cnt_q != {SCNT_W{1'b1}}) begin
        cnt_d = cnt_q + SCNT_W'(1);
      end

      unique case (state_q)
        S_IDLE: begin
          state_d = (q_in == PAT0) ? S_GOT0 : S_IDLE;
        end
        S_GOT0: begin
          if (q_in == PAT1)      state_d = S_GOT1;
          else if (q_in == PAT0) state_d = S_GOT0;
          else                   state_d = S_IDLE;
        end
        S_GOT1: begin
          if (q_in == PAT2) begin
            match_d = 1'b1;
            state_d = (PAT2 == PAT0) ? S_GOT0 : S_IDLE;
          end else if (q_in == PAT0) begin
            state_d = S_GOT0;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      match_q     <= 1'b0;
      step_err_q  <= 1'b0;
      overflow_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      match_q     <= match_d;
      step_err_q  <= step_err_d;
      overflow_q  <= overflow_d;
      cnt_q       <= cnt_d;
    end
  end

  assign match      = match_q;
  assign step_err   = step_err_q;
  assign overflow   = overflow_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_nibble_stream_monitor.sv
// Scoreboard bench: stimulus queues expected per-edge flags and FIFO data,
// a negedge monitor pops and compares them against the DUT.
module tb_nibble_stream_monitor;

  typedef struct {
    int         edge_n;
    logic       m;
    logic       se;
    logic       ov;
    logic       ovf;
    logic [7:0] cnt;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [3:0] q_in;
  logic       valid_in;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       match;
  logic       step_err;
  logic       overflow;
  logic [7:0] sample_cnt;

  exp_t       eq[$];
  logic [3:0] dq[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  int         occ = 0;
  logic       m_ovf = 1'b0;
  int         m_cnt = 0;

  nibble_stream_monitor dut (
    .clk       (clk),
    .reset     (reset),
    .q_in      (q_in),
    .valid_in  (valid_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .match     (match),
    .step_err  (step_err),
    .overflow  (overflow),
    .sample_cnt(sample_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s edge=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Drive one cycle; em/ese are the hand-computed match/step_err after this edge.
  task automatic drive(input logic rst, input logic v, input logic [3:0] d,
                       input logic rdy, input logic em, input logic ese);
    exp_t e;
    bit   pop;
    reset     = rst;
    valid_in  = v;
    q_in      = d;
    out_ready = rdy;
    if (rst) begin
      occ   = 0;
      m_ovf = 1'b0;
      m_cnt = 0;
      dq.delete();
    end else begin
      pop = (occ > 0) && rdy;
      if (v) begin
        if (occ == 4 && !pop) begin
          m_ovf = 1'b1;
        end else begin
          dq.push_back(d);
          occ++;
        end
        if (m_cnt < 255) m_cnt++;
      end
      if (pop) occ--;
    end
    e.edge_n = cyc + 1;
    e.m      = em;
    e.se     = ese;
    e.ov     = (occ > 0);
    e.ovf    = m_ovf;
    e.cnt    = 8'(m_cnt);
    eq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0, rdy, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: per-edge flag checks plus FIFO data pops on accepted handshakes.
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] d;
    if (eq.size() > 0 && eq[0].edge_n == cyc) begin
      e = eq.pop_front();
      check("match", int'(match), int'(e.m));
      check("step_err", int'(step_err), int'(e.se));
      check("out_valid", int'(out_valid), int'(e.ov));
      check("overflow", int'(overflow), int'(e.ovf));
      check("sample_cnt", int'(sample_cnt), int'(e.cnt));
      if (!e.ov) check("out_data_idle", int'(out_data), 0);
    end
    if (out_valid && out_ready) begin
      if (dq.size() == 0) begin
        check("unexpected_pop", 1, 0);
      end else begin
        d = dq.pop_front();
        check("out_data", int'(out_data), int'(d));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog edge=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    // 1: reset two cycles, then idle
    do_reset();
    do_reset();
    idle(1'b0, 5);

    // 2: 3,4,5 with sink ready
    drive(1'b0, 1'b1, 4'h3, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'h4, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'h5, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 2);

    // 3: 3,3,4,5 -> step error after second 3, match after 5
    do_reset();
    drive(1'b0, 1'b1, 4'h3, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'h3, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 4'h4, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'h5, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 2);

    // 4: sink stalled, 1..5 overflows on 5 (3,4,5 also matches), then drain
    do_reset();
    drive(1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'h4, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 5);

    // 5: wrap E,F,0,1 is a legal step sequence
    do_reset();
    drive(1'b0, 1'b1, 4'hE, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 2);

    // 7: full FIFO with simultaneous push and pop drops nothing
    do_reset();
    drive(1'b0, 1'b1, 4'h8, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'hC, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 5);

    // 6: overflow with two entries left, then reset with valid_in high
    do_reset();
    drive(1'b0, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'h8, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 2);
    idle(1'b0, 1);
    drive(1'b1, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 2);
    // first sample after reset must not flag a step error
    drive(1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 3);

    waited = 0;
    while ((eq.size() > 0 || dq.size() > 0) && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    check("flags_drained", eq.size(), 0);
    check("data_drained", dq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
